// File: rtl/counter_checker_pkg.sv
// Shared types and the counter next-value rule for the up/down/load counter checker.
package counter_chk_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, FAIL} chk_state_t;

  localparam int unsigned CNT_FN_W = 32;

  // Callers size-cast the result down to their own data width; the modulo wrap falls out of the truncation.
  function automatic logic [CNT_FN_W-1:0] cnt_next(input logic [CNT_FN_W-1:0] v,
                                                   input logic                 ld,
                                                   input logic                 updn,
                                                   input logic [CNT_FN_W-1:0] data);
    if (ld)
      return data;
    else if (updn)
      return v + CNT_FN_W'(1);
    else
      return v - CNT_FN_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/counter_checker.sv
// Passive checker: tracks the observed counter stimulus with a reference model and
// scores the counter output against it every clock.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             clr,
  input  logic             ld,
  input  logic             updn,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] exp_data,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic             fail
);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q;
  logic [WIDTH-1:0] first_exp_q, first_act_q;
  logic             first_seen_q;
  logic             active, compare, mismatch, at_limit;

  always_comb begin
    active   = (state_q != IDLE);
    compare  = active && chk_en && !clr;
    mismatch = compare && (rd_data != exp_q);
    at_limit = (err_cnt >= CNT_W'(ERR_LIMIT - 1));

    // While idle the model follows the DUT so that enabling never starts from a stale value.
    if (active)
      exp_d = WIDTH'(cnt_next(CNT_FN_W'(exp_q), ld, updn, CNT_FN_W'(data)));
    else
      exp_d = WIDTH'(cnt_next(CNT_FN_W'(rd_data), ld, updn, CNT_FN_W'(data)));

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (chk_en) state_d = CHECK;
      CHECK: begin
        if (!chk_en)                  state_d = IDLE;
        else if (mismatch && at_limit) state_d = FAIL;
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      err_q        <= 1'b0;
      first_exp_q  <= '0;
      first_act_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= mismatch;
      if (clr) begin
        first_exp_q  <= '0;
        first_act_q  <= '0;
        first_seen_q <= 1'b0;
      end else if (mismatch && !first_seen_q) begin
        first_exp_q  <= exp_q;
        first_act_q  <= rd_data;
        first_seen_q <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (mismatch),
    .cnt (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (compare),
    .cnt (chk_cnt)
  );

  assign exp_data  = exp_q;
  assign err       = err_q;
  assign first_exp = first_exp_q;
  assign first_act = first_act_q;
  assign fail      = (state_q == FAIL);

endmodule
